pipelined_ripple_adder: RTL and testbench
=========================================

Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined successor to the combinational generate-loop ripple adder. The WIDTH-bit operand is split into STAGES equal chunks. Each chunk is a gate-level ripple slice, and the carry between slices is registered. Adds add/subtract mode, valid/ready flow control with backpressure, and unsigned carry plus signed overflow flags. Sits in the datapath between operand registers and an accumulator or ALU result mux.

Parameters:
- WIDTH, 8, operand/result width in bits.
- STAGES, 2, pipeline depth (number of ripple slices); WIDTH % STAGES must be 0, otherwise elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  add: carry-out; sub: 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Arithmetic:
  - Effective B is b ^ {WIDTH{sub}}; effective carry-in is cin ^ sub.
  - Sub therefore computes a + ~b + !cin.
  - ovf = carry into MSB XOR carry out of MSB.
  - Results are modulo 2^WIDTH.
- Slicing:
  - Slice k handles bits [k*W/S +: W/S].
  - Slice k is built as full-adder cells in a generate loop (xor/and per bit, as in the existing adder).
  - Slice k's carry-in is the registered carry-out of slice k-1, or the effective cin for k=0.
- Pipeline registers:
  - Stage k holds: valid bit, sum bits produced so far, carry, and the not-yet-consumed upper operand bits.
  - Those upper operand bits are skewed forward unchanged, together with the sub bit.
- Latency:
  - Exactly STAGES cycles from an accepted input (in_valid && in_ready at edge t) to out_valid at edge t+STAGES, absent stalls.
  - Throughput is one beat per cycle.
- Flow control:
  - Global advance enable en = !out_valid || out_ready; in_ready = en (combinational).
  - When en=0, all stage registers hold (valid and data).
  - When en=1, every stage shifts; a bubble (valid 0) enters if in_valid=0.
  - Bubbles are not compressed; the whole pipe stalls together.
- Output:
  - sum/cout/ovf are driven from the final stage register and are stable while out_valid && !out_ready.
  - Data when out_valid=0 is don't-care, but must be 0 after reset.
- Reset (async, rst_n low):
  - All valid bits 0, all data/carry registers 0.
  - Hence out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 immediately, because out_valid=0.
  - Reset mid-operation discards all in-flight beats; no partial result is emitted after release.
- STAGES=1: a single slice with an output register; latency 1.
- Simultaneous accept and drain with a full pipe (in_valid, out_ready both 1): one beat out, one beat in, no loss or duplication.
- Operand changes while in_valid=0 or in_ready=0 have no effect.

Test Plan (WIDTH=8, STAGES=2 unless noted):
1. Reset then a=0x3C, b=0x51, cin=0, sub=0, out_ready=1 -> out_valid exactly 2 cycles after accept; sum=0x8D, cout=0, ovf=1.
2. Carry across slice boundary: a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
3. Subtract: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
4. Backpressure: stream 5 beats back-to-back, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold, outputs held stable, all 5 results in order with no duplicates.
5. Assert rst_n low with 2 beats in flight -> out_valid=0 and sum=0 asynchronously; no stale result emitted after release.
6. Random 1000 beats, WIDTH=16 with STAGES in {1,4,16}, random in_valid/out_ready -> scoreboard matches a + (sub ? ~b + !cin : b + cin) for sum, cout and ovf.

Source files
------------

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES ripple slices with a
// registered carry between them, a stall-together valid/ready pipe, and carry/overflow flags.

module pra_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o
);
    logic [W-1:0] be;
    logic [W:0]   c;

    assign be   = b_i ^ {W{sub_i}};
    assign c[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ be[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & be[i]) | (c[i] & (a_i[i] ^ be[i]));
    end

    assign cout_o = c[W];
endmodule

module pipelined_ripple_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES");
    end

    // The whole pipe advances or holds as one; no bubble squeezing.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : st
        localparam int IW = WIDTH - k * SW;

        logic                  vld_in;
        logic                  sub_in;
        logic                  c_in;
        logic [IW-1:0]         a_in;
        logic [IW-1:0]         b_in;
        logic [SW-1:0]         s_sl;
        logic                  co_sl;
        logic [(k+1)*SW-1:0]   s_d;
        logic                  vld_q;
        logic                  c_q;
        logic [(k+1)*SW-1:0]   s_q;

        if (k == 0) begin : g_src
            assign vld_in = in_valid;
            assign sub_in = sub;
            assign c_in   = cin ^ sub;
            assign a_in   = a;
            assign b_in   = b;
            assign s_d    = s_sl;
        end else begin : g_src
            assign vld_in = st[k-1].vld_q;
            assign sub_in = st[k-1].g_fwd.sub_q;
            assign c_in   = st[k-1].c_q;
            assign a_in   = st[k-1].g_fwd.a_q;
            assign b_in   = st[k-1].g_fwd.b_q;
            assign s_d    = {s_sl, st[k-1].s_q};
        end

        pra_slice #(.W(SW)) u_slice (
            .a_i    (a_in[SW-1:0]),
            .b_i    (b_in[SW-1:0]),
            .sub_i  (sub_in),
            .cin_i  (c_in),
            .s_o    (s_sl),
            .cout_o (co_sl)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (en) begin
                vld_q <= vld_in;
                c_q   <= co_sl;
                s_q   <= s_d;
            end
        end

        // Operand bits above this slice ride along untouched for the later slices.
        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SW-1:0] a_q;
            logic [IW-SW-1:0] b_q;
            logic             sub_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (en) begin
                    a_q   <= a_in[IW-1:SW];
                    b_q   <= b_in[IW-1:SW];
                    sub_q <= sub_in;
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic ovf_d;

            // Same-sign operands producing an opposite-sign result.
            assign ovf_d = (a_in[SW-1] == (b_in[SW-1] ^ sub_in)) && (s_sl[SW-1] != a_in[SW-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = st[STAGES-1].vld_q;
    assign sum       = st[STAGES-1].s_q;
    assign cout      = st[STAGES-1].c_q;
    assign ovf       = st[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench: directed vectors on an 8-bit/2-stage instance, random streams on
// 16-bit instances with 1, 4 and 16 stages, all checked against an arithmetic model.

module tb_pipelined_ripple_adder;
    logic        clk = 1'b0;
    logic        d_rst_n;
    logic        d_in_valid, d_out_ready, d_cin, d_sub;
    logic [15:0] d_a, d_b;
    logic        d_in_ready, d_out_valid, d_cout, d_ovf;
    logic [7:0]  d_sum;

    int checks = 0;
    int errors = 0;
    bit lat_chk = 1'b0;
    bit start_rand = 1'b0;
    int n_done = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] r;
        int          acc_n;
    } exp_t;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // {ovf, cout, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        longint mask, ua, ub, full, half, sa, sb, res;
        logic [17:0] r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = sub ? ua + ((~ub) & mask) + (cin ? 0 : 1) : ua + ub + longint'(cin);
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        res  = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        r[15:0] = 16'(full & mask);
        r[16]   = ((full >> w) & 1) != 0;
        r[17]   = (res < -half) || (res >= half);
        return r;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g
        localparam int W = (gi == 0) ? 8 : 16;
        localparam int S = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 16;

        logic         in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
        logic [W-1:0] a, b, sum;
        logic         rv_valid, rv_ready, rv_cin, rv_sub;
        logic [15:0]  rv_a, rv_b;

        exp_t        q[$];
        int          n_acc = 0;
        int          n_out = 0;
        int          ncyc = 0;
        bit          held = 1'b0;
        bit          last_acc = 1'b0;
        logic [17:0] hv;

        pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
            .clk       (clk),
            .rst_n     (d_rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        if (gi == 0) begin : g_dir
            assign in_valid    = d_in_valid;
            assign out_ready   = d_out_ready;
            assign a           = d_a[W-1:0];
            assign b           = d_b[W-1:0];
            assign cin         = d_cin;
            assign sub         = d_sub;
            assign d_in_ready  = in_ready;
            assign d_out_valid = out_valid;
            assign d_sum       = sum[7:0];
            assign d_cout      = cout;
            assign d_ovf       = ovf;
        end else begin : g_rnd
            assign in_valid  = rv_valid;
            assign out_ready = rv_ready;
            assign a         = rv_a[W-1:0];
            assign b         = rv_b[W-1:0];
            assign cin       = rv_cin;
            assign sub       = rv_sub;

            initial begin
                int cyc = 0;
                rv_valid = 1'b0; rv_ready = 1'b1; rv_a = '0; rv_b = '0; rv_cin = 1'b0; rv_sub = 1'b0;
                wait (start_rand);
                while (cyc < 20000) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (n_acc >= 1000) break;
                    if (last_acc || !rv_valid) begin
                        rv_valid = ($urandom_range(0, 9) < 7);
                        rv_a     = 16'($urandom);
                        rv_b     = 16'($urandom);
                        rv_cin   = 1'($urandom);
                        rv_sub   = 1'($urandom);
                    end
                    rv_ready = ($urandom_range(0, 9) < 7);
                end
                rv_valid = 1'b0;
                rv_ready = 1'b1;
                repeat (S + 4) @(posedge clk);
                #1;
                chk($sformatf("g%0d_drain", gi), n_out, n_acc);
                chk($sformatf("g%0d_beats", gi), n_acc, 1000);
                n_done++;
            end
        end

        // Inputs and outputs are stable at the falling edge; what is seen here
        // is what the next rising edge will transfer.
        always @(negedge clk) begin
            exp_t e;
            ncyc++;
            if (!d_rst_n) begin
                q.delete();
                held     = 1'b0;
                last_acc = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    n_out++;
                    if (q.size() == 0) begin
                        chk($sformatf("g%0d_extra_out", gi), q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("g%0d_sum", gi), sum, e.r[W-1:0]);
                        chk($sformatf("g%0d_cout", gi), cout, e.r[16]);
                        chk($sformatf("g%0d_ovf", gi), ovf, e.r[17]);
                        if (gi == 0 && lat_chk) chk("latency", ncyc - e.acc_n, S);
                    end
                end
                if (out_valid && !out_ready) begin
                    chk($sformatf("g%0d_in_ready_hold", gi), in_ready, 0);
                    if (held) chk($sformatf("g%0d_hold_stable", gi), {ovf, cout, 16'(sum)}, hv);
                    held = 1'b1;
                    hv   = {ovf, cout, 16'(sum)};
                end else begin
                    held = 1'b0;
                end
                last_acc = in_valid && in_ready;
                if (last_acc) begin
                    e.r     = model(W, 16'(a), 16'(b), cin, sub);
                    e.acc_n = ncyc;
                    q.push_back(e);
                    n_acc++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] a_, input logic [7:0] b_, input logic c_, input logic s_);
        int  n = 0;
        bit  ok = 1'b0;
        @(posedge clk); #1;
        d_in_valid = 1'b1;
        d_a = {8'h00, a_}; d_b = {8'h00, b_}; d_cin = c_; d_sub = s_;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = d_in_ready;
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        d_in_valid = 1'b0;
    endtask

    initial begin
        int snap;
        d_rst_n = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1;
        d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
        #2;
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_sum", d_sum, 0);
        chk("rst_cout", d_cout, 0);
        chk("rst_ovf", d_ovf, 0);
        chk("rst_in_ready", d_in_ready, 1);
        repeat (2) @(posedge clk);
        #1 d_rst_n = 1'b1;

        chk("pin_3c_51", model(8, 16'h3C, 16'h51, 0, 0), 18'h2008D);
        chk("pin_0f_01", model(8, 16'h0F, 16'h01, 0, 0), 18'h00010);
        chk("pin_ff_00c", model(8, 16'hFF, 16'h00, 1, 0), 18'h10000);
        chk("pin_05m07", model(8, 16'h05, 16'h07, 0, 1), 18'h000FE);
        chk("pin_80m01", model(8, 16'h80, 16'h01, 0, 1), 18'h3007F);

        // Basic add, slice-boundary carries and subtracts with no stalls.
        lat_chk = 1'b1;
        send(8'h3C, 8'h51, 1'b0, 1'b0);
        send(8'h0F, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b1, 1'b0);
        send(8'h05, 8'h07, 1'b0, 1'b1);
        send(8'h80, 8'h01, 1'b0, 1'b1);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("n_out_t123", g[0].n_out, 5);
        lat_chk = 1'b0;

        // Backpressure mid-stream.
        fork
            begin
                repeat (3) @(posedge clk);
                #1 d_out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 d_out_ready = 1'b1;
            end
        join_none
        send(8'h12, 8'h34, 1'b0, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'hA5, 8'h5A, 1'b1, 1'b1);
        send(8'h00, 8'h01, 1'b1, 1'b1);
        send(8'hC8, 8'h9C, 1'b1, 1'b0);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("n_out_t4", g[0].n_out, 10);
        chk("drain_t4", g[0].n_out, g[0].n_acc);

        // Reset with two beats in flight.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        chk("pre_rst_valid", d_out_valid, 1);
        snap = g[0].n_out;
        #2 d_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", d_out_valid, 0);
        chk("arst_sum", d_sum, 0);
        chk("arst_in_ready", d_in_ready, 1);
        repeat (2) @(posedge clk);
        #1 d_rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_stale_out", g[0].n_out, snap);

        start_rand = 1'b1;
        fork
            wait (n_done == 3);
            #400000;
        join_any
        disable fork;
        chk("random_done", n_done, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
